// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared types and helpers for the counter bank.
//   sel_width  - read-select width for a given channel count (minimum 1)
//   next_count_t - next-count result {value, wrap}
//   clamp_max  - limit a value to the terminal count
//   eff_step   - effective step (0 reads as 1, clamped to terminal count)
// All helpers operate at CB_MAX_W bits so any legal counter width fits.
package counter_bank_pkg;

  localparam int unsigned CB_MAX_W = 32;

  typedef struct packed {
    logic [CB_MAX_W-1:0] value;
    logic                wrap;
  } next_count_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [CB_MAX_W-1:0] clamp_max(input logic [CB_MAX_W-1:0] v,
                                                     input logic [CB_MAX_W-1:0] max_count);
    return (v > max_count) ? max_count : v;
  endfunction

  function automatic logic [CB_MAX_W-1:0] eff_step(input logic [CB_MAX_W-1:0] step,
                                                    input logic [CB_MAX_W-1:0] max_count);
    return clamp_max((step == '0) ? CB_MAX_W'(1) : step, max_count);
  endfunction

endpackage

// File: rtl/counter_bank_chan.sv
// counter_bank_chan: one up/down counter channel with wrap or saturate,
// registered zero/max flags and a one-cycle wrap event.
// Ports: clk, rst_n (async, active-low), clken (global hold), load/incr/decr/sat
// controls, load_value, step; outputs count, is_zero, at_max, wrap_evt.
// Optional feature macro: COUNTER_BANK_SAT_EN (honour sat; otherwise always wrap).
module counter_bank_chan
  import counter_bank_pkg::*;
#(
  parameter int unsigned        C_WIDTH   = 8,
  parameter int unsigned        C_STEP_W  = 4,
  parameter logic [C_WIDTH-1:0] MAX_COUNT = '1,
  parameter logic [C_WIDTH-1:0] C_INIT    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clken,
  input  logic                load,
  input  logic                incr,
  input  logic                decr,
  input  logic                sat,
  input  logic [C_WIDTH-1:0]  load_value,
  input  logic [C_STEP_W-1:0] step,
  output logic [C_WIDTH-1:0]  count,
  output logic                is_zero,
  output logic                at_max,
  output logic                wrap_evt
);

  localparam logic [CB_MAX_W-1:0] MAX_EXT = CB_MAX_W'(MAX_COUNT);
  localparam logic [CB_MAX_W:0]   MODULUS = {1'b0, MAX_EXT} + (CB_MAX_W+1)'(1);

  logic sat_on;
`ifdef COUNTER_BANK_SAT_EN
  assign sat_on = sat;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign sat_on     = 1'b0;
`endif

  logic [CB_MAX_W:0]   cnt_ext;
  logic [CB_MAX_W:0]   step_s;
  logic [CB_MAX_W:0]   sum;
  logic [CB_MAX_W-1:0] step_raw;
  logic [CB_MAX_W-1:0] ld_ext;
  next_count_t         nxt;
  logic                nxt_zero;
  logic                nxt_max;
  logic                unused_nxt;

  // Arithmetic is one bit wider than the counter so count + step never overflows.
  always_comb begin
    cnt_ext                = '0;
    cnt_ext[C_WIDTH-1:0]   = count;
    step_raw               = '0;
    step_raw[C_STEP_W-1:0] = step;
    ld_ext                 = '0;
    ld_ext[C_WIDTH-1:0]    = load_value;
    step_s                 = {1'b0, eff_step(step_raw, MAX_EXT)};
    sum                    = cnt_ext + step_s;
    nxt.value              = cnt_ext[CB_MAX_W-1:0];
    nxt.wrap               = 1'b0;
    if (load) begin
      nxt.value = clamp_max(ld_ext, MAX_EXT);
    end else if (incr && !decr) begin
      if (sum > {1'b0, MAX_EXT}) begin
        nxt.wrap  = 1'b1;
        nxt.value = sat_on ? MAX_EXT : CB_MAX_W'(sum - MODULUS);
      end else begin
        nxt.value = sum[CB_MAX_W-1:0];
      end
    end else if (decr && !incr) begin
      if (cnt_ext < step_s) begin
        nxt.wrap  = 1'b1;
        nxt.value = sat_on ? '0 : CB_MAX_W'(cnt_ext + MODULUS - step_s);
      end else begin
        nxt.value = CB_MAX_W'(cnt_ext - step_s);
      end
    end
  end

  // Flags derive from the next value so they land in the same cycle as count.
  assign nxt_zero   = (nxt.value == '0);
  assign nxt_max    = (nxt.value == MAX_EXT);
  assign unused_nxt = ^nxt.value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= C_INIT;
      is_zero  <= (C_INIT == '0);
      at_max   <= (C_INIT == MAX_COUNT);
      wrap_evt <= 1'b0;
    end else if (clken) begin
      count    <= nxt.value[C_WIDTH-1:0];
      is_zero  <= nxt_zero;
      at_max   <= nxt_max;
      wrap_evt <= nxt.wrap;
    end else begin
      wrap_evt <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// counter_bank: C_CHANNELS independent up/down counters plus a registered
// read port returning one channel's pre-update count.
// Ports: clk, rst_n (async, active-low), clken, per-channel load/incr/decr/sat,
// flattened load_value/step in, flattened count/is_zero/at_max/wrap_evt out,
// rd_sel/rd_en in, rd_data/rd_valid out.
// Optional feature macro: COUNTER_BANK_SAT_EN (per-channel saturate mode).
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned        C_CHANNELS = 4,
  parameter int unsigned        C_WIDTH    = 8,
  parameter int unsigned        C_STEP_W   = 4,
  parameter logic [C_WIDTH-1:0] MAX_COUNT  = '1,
  parameter logic [C_WIDTH-1:0] C_INIT     = '0,
  localparam int unsigned       SEL_W      = sel_width(C_CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clken,
  input  logic [C_CHANNELS-1:0]          load,
  input  logic [C_CHANNELS-1:0]          incr,
  input  logic [C_CHANNELS-1:0]          decr,
  input  logic [C_CHANNELS-1:0]          sat,
  input  logic [C_CHANNELS*C_WIDTH-1:0]  load_value,
  input  logic [C_CHANNELS*C_STEP_W-1:0] step,
  output logic [C_CHANNELS*C_WIDTH-1:0]  count,
  output logic [C_CHANNELS-1:0]          is_zero,
  output logic [C_CHANNELS-1:0]          at_max,
  output logic [C_CHANNELS-1:0]          wrap_evt,
  input  logic [SEL_W-1:0]               rd_sel,
  input  logic                           rd_en,
  output logic [C_WIDTH-1:0]             rd_data,
  output logic                           rd_valid
);

  localparam int unsigned SEL_N = 1 << SEL_W;

  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_chan
    counter_bank_chan #(
      .C_WIDTH  (C_WIDTH),
      .C_STEP_W (C_STEP_W),
      .MAX_COUNT(MAX_COUNT),
      .C_INIT   (C_INIT)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .clken     (clken),
      .load      (load[i]),
      .incr      (incr[i]),
      .decr      (decr[i]),
      .sat       (sat[i]),
      .load_value(load_value[i*C_WIDTH +: C_WIDTH]),
      .step      (step[i*C_STEP_W +: C_STEP_W]),
      .count     (count[i*C_WIDTH +: C_WIDTH]),
      .is_zero   (is_zero[i]),
      .at_max    (at_max[i]),
      .wrap_evt  (wrap_evt[i])
    );
  end

  // Read table padded to the full select range: unused selects read back 0.
  logic [C_WIDTH-1:0] rd_tbl [SEL_N];

  for (genvar j = 0; j < SEL_N; j++) begin : g_rd
    if (j < C_CHANNELS) begin : g_live
      assign rd_tbl[j] = count[j*C_WIDTH +: C_WIDTH];
    end else begin : g_pad
      assign rd_tbl[j] = '0;
    end
  end

  // Read port runs independently of clken and samples the pre-update count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_tbl[rd_sel];
      end
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int SW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clken;
  logic [N-1:0]   load, incr, decr, sat;
  logic [N*W-1:0] load_value;
  logic [N*SW-1:0] step;
  logic [N*W-1:0] count;
  logic [N-1:0]   is_zero, at_max, wrap_evt;
  logic [2:0]     rd_sel;
  logic           rd_en;
  logic [W-1:0]   rd_data;
  logic           rd_valid;

  int n_assert = 0;
  int n_fail   = 0;

  counter_bank #(
    .C_CHANNELS(N),
    .C_WIDTH   (W),
    .C_STEP_W  (SW),
    .MAX_COUNT (8'd9),
    .C_INIT    (8'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clken     (clken),
    .load      (load),
    .incr      (incr),
    .decr      (decr),
    .sat       (sat),
    .load_value(load_value),
    .step      (step),
    .count     (count),
    .is_zero   (is_zero),
    .at_max    (at_max),
    .wrap_evt  (wrap_evt),
    .rd_sel    (rd_sel),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int i);
    return count[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clken = 1'b0;
    load = '0; incr = '0; decr = '0; sat = '0;
    load_value = '0; step = '0; rd_sel = '0; rd_en = 1'b0;
    tick(); tick();

    for (int i = 0; i < N; i++) chk($sformatf("reset_count%0d", i), 32'(cnt(i)), 32'd3);
    chk("reset_is_zero", 32'(is_zero), 32'd0);
    chk("reset_at_max", 32'(at_max), 32'd0);
    chk("reset_wrap", 32'(wrap_evt), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);

    rst_n = 1'b1; clken = 1'b1;

    // ch0: load 8, then wrapping increment by 3
    load[0] = 1'b1; load_value[0*W +: W] = 8'd8; step[0*SW +: SW] = 4'd3;
    tick();
    chk("load_ch0", 32'(cnt(0)), 32'd8);
    load[0] = 1'b0; incr[0] = 1'b1;
    tick();
    chk("wrap_inc_count", 32'(cnt(0)), 32'd1);
    chk("wrap_inc_evt", 32'(wrap_evt[0]), 32'd1);
    chk("wrap_inc_zero", 32'(is_zero[0]), 32'd0);
    incr[0] = 1'b0;
    tick();
    chk("wrap_evt_one_cycle", 32'(wrap_evt[0]), 32'd0);
    chk("hold_count", 32'(cnt(0)), 32'd1);

    // wrapping decrement: 1 - 3 -> 8
    decr[0] = 1'b1;
    tick();
    chk("wrap_dec_count", 32'(cnt(0)), 32'd8);
    chk("wrap_dec_evt", 32'(wrap_evt[0]), 32'd1);

    // 1 - 1 -> 0 with is_zero in the same cycle
    decr[0] = 1'b0; load[0] = 1'b1; load_value[0*W +: W] = 8'd1;
    tick();
    load[0] = 1'b0; decr[0] = 1'b1; step[0*SW +: SW] = 4'd1;
    tick();
    chk("dec_to_zero_count", 32'(cnt(0)), 32'd0);
    chk("dec_to_zero_flag", 32'(is_zero[0]), 32'd1);
    chk("dec_to_zero_evt", 32'(wrap_evt[0]), 32'd0);

    // incr and decr together hold
    incr[0] = 1'b1;
    tick();
    chk("incr_decr_hold", 32'(cnt(0)), 32'd0);
    chk("incr_decr_no_evt", 32'(wrap_evt[0]), 32'd0);
    incr[0] = 1'b0; decr[0] = 1'b0;

    // ch1: load beats incr, load value clamped to MAX
    load[1] = 1'b1; incr[1] = 1'b1; load_value[1*W +: W] = 8'd12; step[1*SW +: SW] = 4'd0;
    tick();
    chk("load_clamp_count", 32'(cnt(1)), 32'd9);
    chk("load_clamp_at_max", 32'(at_max[1]), 32'd1);
    chk("load_no_evt", 32'(wrap_evt[1]), 32'd0);
    // step 0 acts as 1: 9 + 1 wraps to 0
    load[1] = 1'b0;
    tick();
    chk("step0_count", 32'(cnt(1)), 32'd0);
    chk("step0_evt", 32'(wrap_evt[1]), 32'd1);
    chk("step0_zero", 32'(is_zero[1]), 32'd1);
    chk("step0_not_max", 32'(at_max[1]), 32'd0);
    // clken low holds and clears wrap_evt
    clken = 1'b0;
    tick();
    chk("clken_hold", 32'(cnt(1)), 32'd0);
    chk("clken_evt_clear", 32'(wrap_evt[1]), 32'd0);
    clken = 1'b1; incr[1] = 1'b0;

    // ch3: step 15 clamps to 9; back-to-back wraps
    load[3] = 1'b1; load_value[3*W +: W] = 8'd9; step[3*SW +: SW] = 4'd15;
    tick();
    load[3] = 1'b0; incr[3] = 1'b1;
    tick();
    chk("b2b_first_count", 32'(cnt(3)), 32'd8);
    chk("b2b_first_evt", 32'(wrap_evt[3]), 32'd1);
    tick();
    chk("b2b_second_count", 32'(cnt(3)), 32'd7);
    chk("b2b_second_evt", 32'(wrap_evt[3]), 32'd1);
    incr[3] = 1'b0;
    tick();
    chk("b2b_end_evt", 32'(wrap_evt[3]), 32'd0);

    // ch2: saturate mode
    sat[2] = 1'b1; load[2] = 1'b1; load_value[2*W +: W] = 8'd8; step[2*SW +: SW] = 4'd5;
    tick();
    load[2] = 1'b0; incr[2] = 1'b1;
    tick();
`ifdef COUNTER_BANK_SAT_EN
    chk("sat_first_count", 32'(cnt(2)), 32'd9);
    chk("sat_first_evt", 32'(wrap_evt[2]), 32'd1);
    tick();
    chk("sat_repeat_count", 32'(cnt(2)), 32'd9);
    chk("sat_repeat_evt", 32'(wrap_evt[2]), 32'd1);
`else
    chk("nosat_first_count", 32'(cnt(2)), 32'd3);
    chk("nosat_first_evt", 32'(wrap_evt[2]), 32'd1);
    tick();
    chk("nosat_second_count", 32'(cnt(2)), 32'd8);
    chk("nosat_second_evt", 32'(wrap_evt[2]), 32'd0);
`endif
    incr[2] = 1'b0; sat[2] = 1'b0;

    // read port: pre-update value while ch2 increments
    load[2] = 1'b1; load_value[2*W +: W] = 8'd7;
    tick();
    load[2] = 1'b0; incr[2] = 1'b1; step[2*SW +: SW] = 4'd1;
    rd_sel = 3'd2; rd_en = 1'b1;
    tick();
    chk("rd_data_pre_update", 32'(rd_data), 32'd7);
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_ch2_after_incr", 32'(cnt(2)), 32'd8);
    incr[2] = 1'b0; rd_sel = 3'd5;
    tick();
    chk("rd_out_of_range_data", 32'(rd_data), 32'd0);
    chk("rd_out_of_range_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b0;
    tick();
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);

    // asynchronous reset mid-run drops a pending rd_valid
    rd_en = 1'b1; rd_sel = 3'd2;
    tick();
    chk("rd_before_reset", 32'(rd_data), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("async_count%0d", i), 32'(cnt(i)), 32'd3);
    chk("async_is_zero", 32'(is_zero), 32'd0);
    chk("async_at_max", 32'(at_max), 32'd0);
    chk("async_wrap", 32'(wrap_evt), 32'd0);
    chk("async_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rd_data", 32'(rd_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
